// File: rtl/ship_render.sv
// Ship/bullet/target renderer with per-frame shadowed geometry, 2-strobe RGB pipeline and collision detect.
// Optional screen border colour is enabled with `define SHIP_RENDER_BORDER_EN.
`timescale 1ns/1ps

module ship_render #(
`ifdef SHIP_RENDER_BORDER_EN
   parameter int          D_WIDTH    = 640,
   parameter int          D_HEIGHT   = 480,
   parameter logic [11:0] BORDER_RGB = 12'hFFF,
`endif
   parameter logic [11:0] SHIP_RGB   = 12'h0F0,
   parameter logic [11:0] BULLET_RGB = 12'hFF0,
   parameter logic [11:0] TARGET_RGB = 12'hF00,
   parameter logic [11:0] BG_RGB     = 12'h000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pix_stb,
   input  logic [11:0] i_px,
   input  logic [11:0] i_py,
   input  logic        i_active,
   input  logic        i_frame_end,
   input  logic [11:0] i_x1,
   input  logic [11:0] i_x2,
   input  logic [11:0] i_y1,
   input  logic [11:0] i_y2,
   input  logic [11:0] i_bx1,
   input  logic [11:0] i_bx2,
   input  logic [11:0] i_by1,
   input  logic [11:0] i_by2,
   input  logic        i_firing,
   input  logic [11:0] i_tx1,
   input  logic [11:0] i_tx2,
   input  logic [11:0] i_ty1,
   input  logic [11:0] i_ty2,
   output logic [11:0] o_rgb,
   output logic        o_hit,
   output logic [7:0]  o_hit_count,
   output logic        o_crash
);

   // state | meaning
   // WAIT  | after reset, output forced black until the first frame end
   // RUN   | normal rendering and collision detection
   typedef enum logic {ST_WAIT, ST_RUN} state_t;

   state_t state, state_nxt;

   logic [11:0] sx1, sx2, sy1, sy2;
   logic [11:0] sbx1, sbx2, sby1, sby2;
   logic [11:0] stx1, stx2, sty1, sty2;
   logic        s_firing;

   logic s1_valid, s1_ship, s1_bullet, s1_target, s1_active;
   logic hit_pending;
   logic run;
   logic ship_c, bullet_c, target_c, hit_c, crash_c;
   logic [11:0] rgb_nxt;

`ifdef SHIP_RENDER_BORDER_EN
   logic s1_border, border_c;
   assign border_c = (i_px == 12'd0) || (i_px == 12'(D_WIDTH - 1)) ||
                     (i_py == 12'd0) || (i_py == 12'(D_HEIGHT - 1));
`endif

   // Half-open containment; degenerate rectangles fall out naturally.
   function automatic logic in_rect(input logic [11:0] px, input logic [11:0] py,
                                    input logic [11:0] x1, input logic [11:0] x2,
                                    input logic [11:0] y1, input logic [11:0] y2);
      return (x1 <= px) && (px < x2) && (y1 <= py) && (py < y2);
   endfunction

   assign run      = (state == ST_RUN);
   assign ship_c   = in_rect(i_px, i_py, sx1, sx2, sy1, sy2);
   assign bullet_c = s_firing & in_rect(i_px, i_py, sbx1, sbx2, sby1, sby2);
   assign target_c = in_rect(i_px, i_py, stx1, stx2, sty1, sty2);
   assign hit_c    = i_pix_stb & i_active & run & bullet_c & target_c;
   assign crash_c  = i_pix_stb & i_active & run & ship_c & target_c;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_WAIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rgb_nxt   = 12'h000;
      case (state)
         ST_WAIT: begin
            if (i_frame_end) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (s1_valid && s1_active) begin
               if (s1_bullet)      rgb_nxt = BULLET_RGB;
               else if (s1_ship)   rgb_nxt = SHIP_RGB;
               else if (s1_target) rgb_nxt = TARGET_RGB;
`ifdef SHIP_RENDER_BORDER_EN
               else if (s1_border) rgb_nxt = BORDER_RGB;
`endif
               else                rgb_nxt = BG_RGB;
            end
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         {sx1, sx2, sy1, sy2}     <= '0;
         {sbx1, sbx2, sby1, sby2} <= '0;
         {stx1, stx2, sty1, sty2} <= '0;
         s_firing    <= 1'b0;
         s1_valid    <= 1'b0;
         s1_ship     <= 1'b0;
         s1_bullet   <= 1'b0;
         s1_target   <= 1'b0;
         s1_active   <= 1'b0;
`ifdef SHIP_RENDER_BORDER_EN
         s1_border   <= 1'b0;
`endif
         o_rgb       <= 12'h000;
         o_hit       <= 1'b0;
         o_hit_count <= 8'd0;
         o_crash     <= 1'b0;
         hit_pending <= 1'b0;
      end else begin
         // The strobe coinciding with frame end still sees the old shadows.
         if (i_frame_end) begin
            {sx1, sx2, sy1, sy2}     <= {i_x1, i_x2, i_y1, i_y2};
            {sbx1, sbx2, sby1, sby2} <= {i_bx1, i_bx2, i_by1, i_by2};
            {stx1, stx2, sty1, sty2} <= {i_tx1, i_tx2, i_ty1, i_ty2};
            s_firing <= i_firing;
         end
         if (i_pix_stb) begin
            s1_valid  <= 1'b1;
            s1_ship   <= ship_c;
            s1_bullet <= bullet_c;
            s1_target <= target_c;
            s1_active <= i_active;
`ifdef SHIP_RENDER_BORDER_EN
            s1_border <= border_c;
`endif
            o_rgb     <= rgb_nxt;
         end
         if (crash_c) o_crash <= 1'b1;
         o_hit <= 1'b0;
         if (i_frame_end && run) begin
            hit_pending <= 1'b0;
            if (hit_pending || hit_c) begin
               o_hit <= 1'b1;
               if (o_hit_count != 8'hFF) o_hit_count <= o_hit_count + 8'd1;
            end
         end else if (hit_c) begin
            hit_pending <= 1'b1;
         end
      end
   end

endmodule
